// File: rtl/node_rx_arbiter_pkg.sv
// rtl/node_rx_arbiter_pkg.sv - shared constants and elaboration helpers for node_rx_arbiter
package node_rx_arbiter_pkg;

   localparam int DATA_W     = 32;
   localparam int NPORTS_MIN = 2;
   localparam int NPORTS_MAX = 16;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/node_rx_arbiter_rr_grant.sv
// rtl/node_rx_arbiter_rr_grant.sv - combinational rotate-priority search starting at ptr
module rr_grant #(
   parameter int nports = 4,
   parameter int idw    = 2
) (
   input  logic [nports-1:0] req,
   input  logic [idw-1:0]    ptr,
   input  logic              en,
   output logic              gnt_valid,
   output logic [idw-1:0]    gnt_idx
);

   logic [idw-1:0] idx;

   // Scan from the farthest offset down so the nearest pending port to ptr wins.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      idx       = '0;
      if (en) begin
         for (int k = nports - 1; k >= 0; k--) begin
            idx = idw'((int'(ptr) + k) % nports);
            if (req[idx]) begin
               gnt_valid = 1'b1;
               gnt_idx   = idx;
            end
         end
      end
   end

endmodule

// File: rtl/node_rx_arbiter.sv
// rtl/node_rx_arbiter.sv - one-entry per-port slots sharing a queue write port round-robin
module node_rx_arbiter
   import node_rx_arbiter_pkg::*;
#(
   parameter int width  = DATA_W,
   parameter int nports = 4,
   parameter int idw    = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [nports-1:0]        rx_alert,
   input  logic [nports*width-1:0]  rx_data,
   input  logic                     q_full,
   input  logic                     clr_ovf,
   output logic                     q_wrEn,
   output logic [width-1:0]         q_data,
   output logic [idw-1:0]           q_src,
   output logic [nports-1:0]        pending,
   output logic [nports-1:0]        overflow
);

   if (nports < NPORTS_MIN || nports > NPORTS_MAX || idw != clog2(nports)) begin : g_bad_cfg
      $fatal(1, "node_rx_arbiter: nports out of range or idw != clog2(nports)");
   end

   logic [width-1:0]  slot_q [nports];
   logic [width-1:0]  slot_d [nports];
   logic [nports-1:0] pending_q, pending_d;
   logic [nports-1:0] overflow_q, overflow_d;
   logic [nports-1:0] ovf_set;
   logic [idw-1:0]    ptr_q, ptr_d;
   logic              q_wrEn_q, q_wrEn_d;
   logic [width-1:0]  q_data_q, q_data_d;
   logic [idw-1:0]    q_src_q, q_src_d;

   logic              gnt_valid;
   logic [idw-1:0]    gnt_idx;

   rr_grant #(
      .nports (nports),
      .idw    (idw)
   ) u_rr_grant (
      .req       (pending_q),
      .ptr       (ptr_q),
      .en        (~q_full),
      .gnt_valid (gnt_valid),
      .gnt_idx   (gnt_idx)
   );

   // A port granted this edge frees its slot, so a coincident alert is a refill, not an overrun.
   always_comb begin
      slot_d    = slot_q;
      pending_d = pending_q;
      ovf_set   = '0;
      for (int i = 0; i < nports; i++) begin
         if (rx_alert[i]) begin
            if (!pending_q[i] || (gnt_valid && gnt_idx == idw'(i))) begin
               slot_d[i]    = rx_data[i*width +: width];
               pending_d[i] = 1'b1;
            end else begin
               ovf_set[i] = 1'b1;
            end
         end else if (gnt_valid && gnt_idx == idw'(i)) begin
            pending_d[i] = 1'b0;
         end
      end
      overflow_d = (overflow_q & ~{nports{clr_ovf}}) | ovf_set;
   end

   always_comb begin
      q_wrEn_d = gnt_valid;
      q_data_d = q_data_q;
      q_src_d  = q_src_q;
      ptr_d    = ptr_q;
      if (gnt_valid) begin
         q_data_d = slot_q[gnt_idx];
         q_src_d  = gnt_idx;
         ptr_d    = (gnt_idx == idw'(nports - 1)) ? '0 : gnt_idx + idw'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < nports; i++) slot_q[i] <= '0;
         pending_q  <= '0;
         overflow_q <= '0;
         ptr_q      <= '0;
         q_wrEn_q   <= 1'b0;
         q_data_q   <= '0;
         q_src_q    <= '0;
      end else begin
         slot_q     <= slot_d;
         pending_q  <= pending_d;
         overflow_q <= overflow_d;
         ptr_q      <= ptr_d;
         q_wrEn_q   <= q_wrEn_d;
         q_data_q   <= q_data_d;
         q_src_q    <= q_src_d;
      end
   end

   assign q_wrEn   = q_wrEn_q;
   assign q_data   = q_data_q;
   assign q_src    = q_src_q;
   assign pending  = pending_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_node_rx_arbiter.sv
// tb/tb_node_rx_arbiter.sv - self-checking bench for node_rx_arbiter with a behavioural model
module tb_node_rx_arbiter;

   localparam int W   = 32;
   localparam int N   = 4;
   localparam int IDW = 2;
   localparam int VW  = 1 + W + IDW + 2 * N;

   logic             clk;
   logic             reset;
   logic [N-1:0]     rx_alert;
   logic [N*W-1:0]   rx_data;
   logic             q_full;
   logic             clr_ovf;
   logic             q_wrEn;
   logic [W-1:0]     q_data;
   logic [IDW-1:0]   q_src;
   logic [N-1:0]     pending;
   logic [N-1:0]     overflow;

   int checks   = 0;
   int failures = 0;

   // Model state: per-port held word, round-robin pointer, expected outputs.
   bit          m_pend [N];
   logic [W-1:0] m_slot [N];
   bit          m_ovf  [N];
   int          m_ptr;
   bit          m_wr;
   logic [W-1:0] m_data;
   int          m_src;

   node_rx_arbiter #(.width(W), .nports(N), .idw(IDW)) dut (
      .clk      (clk),
      .reset    (reset),
      .rx_alert (rx_alert),
      .rx_data  (rx_data),
      .q_full   (q_full),
      .clr_ovf  (clr_ovf),
      .q_wrEn   (q_wrEn),
      .q_data   (q_data),
      .q_src    (q_src),
      .pending  (pending),
      .overflow (overflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [N-1:0] to_vec(input bit a [N]);
      logic [N-1:0] v;
      for (int i = 0; i < N; i++) v[i] = a[i];
      return v;
   endfunction

   function logic [VW-1:0] exp_vec();
      return {m_wr, m_data, IDW'(m_src), to_vec(m_pend), to_vec(m_ovf)};
   endfunction

   function logic [VW-1:0] obs_vec();
      return {q_wrEn, q_data, q_src, pending, overflow};
   endfunction

   task automatic model_edge();
      int g;
      logic [W-1:0] out_word;
      g = -1;
      if (reset) begin
         for (int i = 0; i < N; i++) begin
            m_pend[i] = 0; m_slot[i] = '0; m_ovf[i] = 0;
         end
         m_ptr = 0; m_wr = 0; m_data = '0; m_src = 0;
         return;
      end
      if (!q_full) begin
         for (int k = 0; k < N; k++) begin
            if (g < 0 && m_pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
         end
      end
      out_word = (g >= 0) ? m_slot[g] : '0;
      if (clr_ovf) for (int i = 0; i < N; i++) m_ovf[i] = 0;
      for (int i = 0; i < N; i++) begin
         if (rx_alert[i]) begin
            if (!m_pend[i] || g == i) begin
               m_slot[i] = rx_data[i*W +: W];
               m_pend[i] = 1;
            end else begin
               m_ovf[i] = 1;
            end
         end else if (g == i) begin
            m_pend[i] = 0;
         end
      end
      if (g >= 0) begin
         m_wr = 1; m_data = out_word; m_src = g; m_ptr = (g + 1) % N;
      end else begin
         m_wr = 0;
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle();
      rx_alert = '0; q_full = 1'b0; clr_ovf = 1'b0; reset = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1;
      cycle();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      rx_data = '1;
      do_reset();
      checks++;
      if (obs_vec() !== '0) begin
         failures++;
         $display("FAIL reset_state got=%h exp=%h", obs_vec(), {VW{1'b0}});
      end
   endtask

   task automatic test_single_word();
      do_reset();
      rx_alert = 4'b0010;
      rx_data[1*W +: W] = 32'hDEADBEEF;
      cycle();
      idle();
      checks++;
      if (q_wrEn !== 1'b0 || pending !== 4'b0010) begin
         failures++;
         $display("FAIL single_capture got wr=%b pend=%b exp wr=0 pend=0010", q_wrEn, pending);
      end
      cycle();
      checks++;
      if (q_wrEn !== 1'b1 || q_data !== 32'hDEADBEEF || q_src !== 2'd1 || pending !== 4'b0000) begin
         failures++;
         $display("FAIL single_grant got wr=%b data=%h src=%0d pend=%b exp 1 deadbeef 1 0000",
                  q_wrEn, q_data, q_src, pending);
      end
      cycle();
      checks++;
      if (q_wrEn !== 1'b0) begin
         failures++;
         $display("FAIL single_one_shot got wr=%b exp 0", q_wrEn);
      end
   endtask

   task automatic test_simultaneous();
      do_reset();
      rx_alert = 4'b1111;
      for (int i = 0; i < N; i++) rx_data[i*W +: W] = 32'hA0 + i;
      cycle();
      idle();
      for (int k = 0; k < N; k++) begin
         cycle();
         checks++;
         if (q_wrEn !== 1'b1 || q_src !== IDW'(k) || q_data !== 32'hA0 + k) begin
            failures++;
            $display("FAIL simul_order_%0d got wr=%b src=%0d data=%h exp 1 %0d %h",
                     k, q_wrEn, q_src, q_data, k, 32'hA0 + k);
         end
      end
      cycle();
      checks++;
      if (q_wrEn !== 1'b0 || pending !== '0) begin
         failures++;
         $display("FAIL simul_drain got wr=%b pend=%b exp 0 0000", q_wrEn, pending);
      end
   endtask

   task automatic test_rotation();
      do_reset();
      rx_alert = 4'b0100; rx_data[2*W +: W] = 32'h2;
      cycle();
      rx_alert = 4'b1001; rx_data[0 +: W] = 32'h10; rx_data[3*W +: W] = 32'h13;
      cycle();
      idle();
      checks++;
      if (q_wrEn !== 1'b1 || q_src !== 2'd2 || pending !== 4'b1001) begin
         failures++;
         $display("FAIL rot_first got wr=%b src=%0d pend=%b exp 1 2 1001", q_wrEn, q_src, pending);
      end
      cycle();
      checks++;
      if (q_src !== 2'd3 || q_data !== 32'h13) begin
         failures++;
         $display("FAIL rot_port3 got src=%0d data=%h exp 3 13", q_src, q_data);
      end
      cycle();
      checks++;
      if (q_src !== 2'd0 || q_data !== 32'h10 || q_wrEn !== 1'b1) begin
         failures++;
         $display("FAIL rot_port0 got wr=%b src=%0d data=%h exp 1 0 10", q_wrEn, q_src, q_data);
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      rx_alert = 4'b0001; rx_data[0 +: W] = 32'h55; q_full = 1'b1;
      cycle();
      rx_alert = '0;
      for (int k = 0; k < 5; k++) begin
         cycle();
         checks++;
         if (q_wrEn !== 1'b0 || pending[0] !== 1'b1) begin
            failures++;
            $display("FAIL bp_stall_%0d got wr=%b pend0=%b exp 0 1", k, q_wrEn, pending[0]);
         end
      end
      q_full = 1'b0;
      cycle();
      checks++;
      if (q_wrEn !== 1'b1 || q_src !== 2'd0 || q_data !== 32'h55) begin
         failures++;
         $display("FAIL bp_release got wr=%b src=%0d data=%h exp 1 0 55", q_wrEn, q_src, q_data);
      end
   endtask

   task automatic test_overrun_refill();
      do_reset();
      rx_alert = 4'b0010; rx_data[W +: W] = 32'h11; q_full = 1'b1;
      cycle();
      rx_data[W +: W] = 32'h22;
      cycle();
      checks++;
      if (overflow !== 4'b0010) begin
         failures++;
         $display("FAIL overrun_flag got=%b exp=0010", overflow);
      end
      idle();
      cycle();
      checks++;
      if (q_wrEn !== 1'b1 || q_data !== 32'h11) begin
         failures++;
         $display("FAIL overrun_keeps_old got wr=%b data=%h exp 1 11", q_wrEn, q_data);
      end
      clr_ovf = 1'b1;
      cycle();
      clr_ovf = 1'b0;
      checks++;
      if (overflow !== '0) begin
         failures++;
         $display("FAIL clr_ovf got=%b exp=0000", overflow);
      end
      rx_alert = 4'b0010; rx_data[W +: W] = 32'h11;
      cycle();
      rx_data[W +: W] = 32'h22;
      cycle();
      idle();
      checks++;
      if (q_wrEn !== 1'b1 || q_data !== 32'h11 || overflow !== '0 || pending[1] !== 1'b1) begin
         failures++;
         $display("FAIL refill got wr=%b data=%h ovf=%b pend1=%b exp 1 11 0000 1",
                  q_wrEn, q_data, overflow, pending[1]);
      end
      cycle();
      checks++;
      if (q_wrEn !== 1'b1 || q_data !== 32'h22 || q_src !== 2'd1) begin
         failures++;
         $display("FAIL refill_deliver got wr=%b data=%h src=%0d exp 1 22 1", q_wrEn, q_data, q_src);
      end
   endtask

   task automatic test_mid_reset();
      idle();
      cycle();
      rx_alert = 4'b0111; q_full = 1'b1;
      cycle();
      checks++;
      if (pending !== 4'b0111) begin
         failures++;
         $display("FAIL midrst_pre got pend=%b exp 0111", pending);
      end
      rx_alert = '0; q_full = 1'b0; reset = 1'b1;
      cycle();
      reset = 1'b0;
      checks++;
      if (pending !== '0 || q_wrEn !== 1'b0) begin
         failures++;
         $display("FAIL midrst_clear got pend=%b wr=%b exp 0000 0", pending, q_wrEn);
      end
      for (int k = 0; k < 3; k++) begin
         cycle();
         checks++;
         if (q_wrEn !== 1'b0) begin
            failures++;
            $display("FAIL midrst_stale_%0d got wr=%b exp 0", k, q_wrEn);
         end
      end
      rx_alert = 4'b1111;
      cycle();
      rx_alert = '0;
      cycle();
      checks++;
      if (q_wrEn !== 1'b1 || q_src !== 2'd0) begin
         failures++;
         $display("FAIL midrst_ptr got wr=%b src=%0d exp 1 0", q_wrEn, q_src);
      end
   endtask

   task automatic test_fairness();
      do_reset();
      rx_alert = 4'b1111;
      cycle();
      for (int k = 0; k < 2 * N; k++) begin
         rx_data = {$urandom, $urandom, $urandom, $urandom};
         cycle();
         checks++;
         if (q_wrEn !== 1'b1 || q_src !== IDW'(k % N)) begin
            failures++;
            $display("FAIL fair_%0d got wr=%b src=%0d exp 1 %0d", k, q_wrEn, q_src, k % N);
         end
      end
      idle();
   endtask

   task automatic test_random();
      do_reset();
      for (int k = 0; k < 400; k++) begin
         rx_alert = N'($urandom) & N'($urandom);
         rx_data  = {$urandom, $urandom, $urandom, $urandom};
         q_full   = ($urandom_range(0, 3) == 0);
         clr_ovf  = ($urandom_range(0, 15) == 0);
         reset    = ($urandom_range(0, 99) == 0);
         cycle();
         checks++;
         if (obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL random_cyc%0d got=%h exp=%h", k, obs_vec(), exp_vec());
         end
      end
      idle();
   endtask

   initial begin
      rx_data = '0;
      idle();
      test_reset();
      test_single_word();
      test_simultaneous();
      test_rotation();
      test_backpressure();
      test_overrun_refill();
      test_mid_reset();
      test_fairness();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
